// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if
//   Bundles the datapath-facing signals of the multi-port register file.
//   master : decode/writeback side (drives addresses, write data, clear pulse)
//   slave  : the register file itself
// Signals:
//   WriteEn, Waddr[D], DataIn[W] : single write port
//   ClearReq                     : one-cycle pulse requesting a clear sweep
//   Raddr[NR*D]                  : packed read addresses, port 0 in the LSBs
//   DataOut[NR*W]                : packed read data, port 0 in the LSBs
//   Ready                        : file initialised and accepting writes
//   ClearIdx[D]                  : current sweep index (debug visibility)
interface regfile_multiport_if #(
   parameter int W  = 8,
   parameter int D  = 4,
   parameter int NR = 3
);
   logic            WriteEn;
   logic [D-1:0]    Waddr;
   logic [W-1:0]    DataIn;
   logic            ClearReq;
   logic [NR*D-1:0] Raddr;
   logic [NR*W-1:0] DataOut;
   logic            Ready;
   logic [D-1:0]    ClearIdx;

   modport master (
      output WriteEn, Waddr, DataIn, ClearReq, Raddr,
      input  DataOut, Ready, ClearIdx
   );

   modport slave (
      input  WriteEn, Waddr, DataIn, ClearReq, Raddr,
      output DataOut, Ready, ClearIdx
   );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Parametrised register file: one write port, NR combinational read ports,
//   optional same-cycle write-to-read bypass and optional hardwired zero
//   entry. After reset, or on a ClearReq pulse, a sequential sweep zeroes
//   one entry per clock; Ready is high only once every entry has been cleared.
// Ports:
//   Clk    : clock, all state updates on the rising edge
//   ResetN : synchronous active-low reset (restarts the clear sweep)
//   bus    : regfile_multiport_if slave modport (write, read, clear, status)
// The interface instance must be built with the same W, D and NR.
module regfile_multiport #(
   parameter int W        = 8,
   parameter int D        = 4,
   parameter int NR       = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                  Clk,
   input  logic                  ResetN,
   regfile_multiport_if.slave    bus
);
   localparam int DEPTH = 2 ** D;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]    state_reg;
   logic [D-1:0]  clear_idx_reg;
   logic [W-1:0]  mem_reg [DEPTH];
   logic          ready;
   logic          write_live;
   logic          write_ok;
   logic [NR*W-1:0] dout;

   assign ready = (state_reg == ST_READY);

   // A write is live only in READY and only when no clear is being requested
   // in the same cycle; the clear pulse wins.
   assign write_live = ready && bus.WriteEn && !bus.ClearReq;

   // Writes to entry 0 are discarded when it is hardwired to zero.
   assign write_ok = write_live && !((ZERO_REG != 0) && (bus.Waddr == '0));

   // Control: state and sweep counter.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_reg     <= ST_CLEAR;
         clear_idx_reg <= '0;
      end else if (state_reg == ST_CLEAR) begin
         // The counter wraps to 0 naturally on the last entry.
         clear_idx_reg <= clear_idx_reg + 1'b1;
         if (&clear_idx_reg) begin
            state_reg <= ST_READY;
         end
      end else if (bus.ClearReq) begin
         state_reg     <= ST_CLEAR;
         clear_idx_reg <= '0;
      end
   end

   // Storage: no reset on the array itself; the sweep provides the zeroing.
   always_ff @(posedge Clk) begin
      if (ResetN) begin
         if (state_reg == ST_CLEAR) begin
            mem_reg[clear_idx_reg] <= '0;
         end else if (write_ok) begin
            mem_reg[bus.Waddr] <= bus.DataIn;
         end
      end
   end

   // Independent combinational read ports.
   generate
      for (genvar gi = 0; gi < NR; gi++) begin : g_rd
         logic [D-1:0] rd_addr;
         logic [W-1:0] rd_data;

         assign rd_addr = bus.Raddr[gi*D +: D];

         always_comb begin
            rd_data = '0;
            if (!ready) begin
               rd_data = '0;
            end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
               // Zero entry overrides bypass as well.
               rd_data = '0;
            end else if ((BYPASS != 0) && write_live && (rd_addr == bus.Waddr)) begin
               rd_data = bus.DataIn;
            end else begin
               rd_data = mem_reg[rd_addr];
            end
         end

         assign dout[gi*W +: W] = rd_data;
      end
   endgenerate

   assign bus.DataOut  = dout;
   assign bus.Ready    = ready;
   assign bus.ClearIdx = clear_idx_reg;
endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
   localparam int DEPTH = 16;

   logic clk;
   int   n_cmp;
   int   n_err;

   // Shared stimulus for the three default-geometry instances.
   logic        rstn;
   logic        we;
   logic [3:0]  waddr;
   logic [7:0]  din;
   logic        clr;
   logic [11:0] raddr;

   // Stimulus for the wide instance (W=16, D=5, NR=4).
   logic        rstn3;
   logic        we3;
   logic [4:0]  waddr3;
   logic [15:0] din3;
   logic        clr3;
   logic [19:0] raddr3;

   regfile_multiport_if #(.W(8), .D(4), .NR(3)) bus_b ();
   regfile_multiport_if #(.W(8), .D(4), .NR(3)) bus_n ();
   regfile_multiport_if #(.W(8), .D(4), .NR(3)) bus_z ();
   regfile_multiport_if #(.W(16), .D(5), .NR(4)) bus_w ();

   assign bus_b.WriteEn = we;  assign bus_b.Waddr = waddr; assign bus_b.DataIn = din;
   assign bus_b.ClearReq = clr; assign bus_b.Raddr = raddr;
   assign bus_n.WriteEn = we;  assign bus_n.Waddr = waddr; assign bus_n.DataIn = din;
   assign bus_n.ClearReq = clr; assign bus_n.Raddr = raddr;
   assign bus_z.WriteEn = we;  assign bus_z.Waddr = waddr; assign bus_z.DataIn = din;
   assign bus_z.ClearReq = clr; assign bus_z.Raddr = raddr;
   assign bus_w.WriteEn = we3; assign bus_w.Waddr = waddr3; assign bus_w.DataIn = din3;
   assign bus_w.ClearReq = clr3; assign bus_w.Raddr = raddr3;

   regfile_multiport #(.W(8), .D(4), .NR(3), .BYPASS(1), .ZERO_REG(0)) dut_b (
      .Clk(clk), .ResetN(rstn), .bus(bus_b));
   regfile_multiport #(.W(8), .D(4), .NR(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
      .Clk(clk), .ResetN(rstn), .bus(bus_n));
   regfile_multiport #(.W(8), .D(4), .NR(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
      .Clk(clk), .ResetN(rstn), .bus(bus_z));
   regfile_multiport #(.W(16), .D(5), .NR(4), .BYPASS(1), .ZERO_REG(0)) dut_w (
      .Clk(clk), .ResetN(rstn3), .bus(bus_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: contents, readiness and how far the sweep has got.
   logic [7:0] m_mem [DEPTH];
   bit         m_ready;
   int         m_cnt;

   // Advance one rising edge and apply the same edge to the model.
   task automatic tick();
      @(posedge clk);
      if (!rstn) begin
         m_ready = 0;
         m_cnt   = 0;
      end else if (!m_ready) begin
         m_mem[m_cnt] = 8'h00;
         m_cnt = m_cnt + 1;
         if (m_cnt == DEPTH) begin
            m_ready = 1;
            m_cnt   = 0;
         end
      end else if (clr) begin
         m_ready = 0;
         m_cnt   = 0;
      end else if (we) begin
         m_mem[waddr] = din;
      end
      #1;
   endtask

   // Expected read value. cfg 0: bypass, 1: no bypass, 2: zero reg + bypass.
   function automatic logic [7:0] exp_rd(input int cfg, input int p);
      logic [3:0] a;
      a = raddr[p*4 +: 4];
      if (!m_ready) return 8'h00;
      if (cfg == 2 && a == 4'd0) return 8'h00;
      if (cfg != 1 && we && !clr && a == waddr) return din;
      return m_mem[a];
   endfunction

   task automatic test_reset();
      rstn = 1'b0; we = 1'b0; clr = 1'b0; waddr = '0; din = '0; raddr = '0;
      repeat (3) tick();
      n_cmp++;
      if (bus_b.Ready !== 1'b0 || bus_b.ClearIdx !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: Ready=%b ClearIdx=%0d, want 0/0", bus_b.Ready, bus_b.ClearIdx);
      end
      rstn = 1'b1;
      for (int e = 0; e < 16; e++) begin
         raddr = 12'($urandom);
         we = 1'($urandom); waddr = 4'($urandom); din = 8'($urandom);
         #2;
         n_cmp++;
         if (bus_b.Ready !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_ready edge %0d: Ready=%b want 0", e, bus_b.Ready);
         end
         n_cmp++;
         if (bus_b.DataOut !== 24'h0 || bus_n.DataOut !== 24'h0 || bus_z.DataOut !== 24'h0) begin
            n_err++;
            $display("FAIL sweep_dout edge %0d: got %h/%h/%h want 0", e,
                     bus_b.DataOut, bus_n.DataOut, bus_z.DataOut);
         end
         tick();
      end
      we = 1'b0;
      #2;
      n_cmp++;
      if (bus_b.Ready !== 1'b1 || bus_n.Ready !== 1'b1 || bus_z.Ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_16: Ready=%b%b%b want 111", bus_b.Ready, bus_n.Ready, bus_z.Ready);
      end
      for (int a = 0; a < DEPTH; a++) begin
         raddr = {3{4'(a)}};
         #1;
         n_cmp++;
         if (bus_b.DataOut !== 24'h0 || bus_n.DataOut !== 24'h0 || bus_z.DataOut !== 24'h0) begin
            n_err++;
            $display("FAIL cleared_entry %0d: got %h/%h/%h want 0", a,
                     bus_b.DataOut, bus_n.DataOut, bus_z.DataOut);
         end
      end
      $display("test_reset: sweep of 16 edges observed");
   endtask

   task automatic test_write_read();
      we = 1'b1; waddr = 4'd3; din = 8'hA5; tick();
      waddr = 4'd7; din = 8'h5A; tick();
      we = 1'b0;
      raddr = {4'd3, 4'd7, 4'd3};
      #2;
      n_cmp++;
      if (bus_b.DataOut !== 24'hA55AA5 || bus_n.DataOut !== 24'hA55AA5) begin
         n_err++;
         $display("FAIL write_read: got %h/%h want a55aa5", bus_b.DataOut, bus_n.DataOut);
      end
      $display("test_write_read: raddr={3,7,3} dout=%h", bus_b.DataOut);
   endtask

   task automatic test_bypass();
      we = 1'b1; waddr = 4'd9; din = 8'h3C; raddr = {4'd0, 4'd9, 4'd0};
      #2;
      n_cmp++;
      if (bus_b.DataOut[15:8] !== 8'h3C) begin
         n_err++;
         $display("FAIL bypass_same_cycle: got %h want 3c", bus_b.DataOut[15:8]);
      end
      n_cmp++;
      if (bus_n.DataOut[15:8] !== 8'h00) begin
         n_err++;
         $display("FAIL nobypass_old: got %h want 00", bus_n.DataOut[15:8]);
      end
      tick();
      we = 1'b0;
      #2;
      n_cmp++;
      if (bus_n.DataOut[15:8] !== 8'h3C) begin
         n_err++;
         $display("FAIL nobypass_next: got %h want 3c", bus_n.DataOut[15:8]);
      end
      $display("test_bypass: addr 9 <= 3c, next-cycle read %h", bus_n.DataOut[15:8]);
   endtask

   task automatic test_zero_reg();
      we = 1'b1; waddr = 4'd0; din = 8'hFF; raddr = 12'h000;
      #2;
      n_cmp++;
      if (bus_z.DataOut !== 24'h0) begin
         n_err++;
         $display("FAIL zero_write_cycle: got %h want 0", bus_z.DataOut);
      end
      n_cmp++;
      if (bus_b.DataOut !== 24'hFFFFFF) begin
         n_err++;
         $display("FAIL zero_ref_bypass: got %h want ffffff", bus_b.DataOut);
      end
      tick();
      we = 1'b0;
      #2;
      n_cmp++;
      if (bus_z.DataOut !== 24'h0) begin
         n_err++;
         $display("FAIL zero_after_write: got %h want 0", bus_z.DataOut);
      end
      $display("test_zero_reg: write ff to addr 0, read %h", bus_z.DataOut);
   endtask

   task automatic test_clear_priority();
      for (int a = 0; a < DEPTH; a++) begin
         we = 1'b1; waddr = 4'(a); din = 8'(a + 1);
         tick();
      end
      clr = 1'b1; we = 1'b1; waddr = 4'd2; din = 8'h77; raddr = {3{4'd2}};
      #2;
      n_cmp++;
      if (bus_b.DataOut[7:0] !== 8'h03) begin
         n_err++;
         $display("FAIL clear_no_bypass: got %h want 03", bus_b.DataOut[7:0]);
      end
      tick();
      clr = 1'b0;
      for (int c = 0; c < 16; c++) begin
         we = 1'b1; waddr = 4'($urandom); din = 8'($urandom);
         #2;
         n_cmp++;
         if (bus_b.Ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ready_low cycle %0d: Ready=%b", c, bus_b.Ready);
         end
         tick();
      end
      we = 1'b0;
      #2;
      n_cmp++;
      if (bus_b.Ready !== 1'b1) begin
         n_err++;
         $display("FAIL clear_ready_rise: Ready=%b want 1", bus_b.Ready);
      end
      for (int a = 0; a < DEPTH; a++) begin
         raddr = {3{4'(a)}};
         #1;
         n_cmp++;
         if (bus_b.DataOut !== 24'h0 || bus_n.DataOut !== 24'h0 || bus_z.DataOut !== 24'h0) begin
            n_err++;
            $display("FAIL clear_entry %0d: got %h/%h/%h want 0", a,
                     bus_b.DataOut, bus_n.DataOut, bus_z.DataOut);
         end
      end
      $display("test_clear_priority: 0x77 dropped, sweep done");
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      clr = 1'b1; tick(); clr = 1'b0;
      n = 0;
      while (bus_b.ClearIdx !== 4'd10 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (bus_b.ClearIdx !== 4'd10) begin
         n_err++;
         $display("FAIL reach_idx10: ClearIdx=%0d want 10", bus_b.ClearIdx);
      end
      rstn = 1'b0;
      tick();
      n_cmp++;
      if (bus_b.ClearIdx !== 4'd0 || bus_b.Ready !== 1'b0) begin
         n_err++;
         $display("FAIL midsweep_reset: ClearIdx=%0d Ready=%b want 0/0", bus_b.ClearIdx, bus_b.Ready);
      end
      rstn = 1'b1;
      n = 0;
      while (bus_b.Ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 16) begin
         n_err++;
         $display("FAIL restart_edges: Ready after %0d edges want 16", n);
      end
      $display("test_reset_mid_sweep: Ready after %0d edges", n);
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         clr   = ($urandom_range(0, 49) == 0);
         we    = 1'($urandom);
         waddr = 4'($urandom);
         din   = 8'($urandom);
         for (int p = 0; p < 3; p++)
            raddr[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom);
         #2;
         n_cmp++;
         if (bus_b.Ready !== m_ready || bus_b.ClearIdx !== 4'(m_cnt)) begin
            n_err++;
            $display("FAIL rand_status cyc %0d: Ready=%b idx=%0d want %b/%0d",
                     c, bus_b.Ready, bus_b.ClearIdx, m_ready, m_cnt);
         end
         for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (bus_b.DataOut[p*8 +: 8] !== exp_rd(0, p)) begin
               n_err++;
               $display("FAIL rand_bypass cyc %0d port %0d: got %h want %h",
                        c, p, bus_b.DataOut[p*8 +: 8], exp_rd(0, p));
            end
            n_cmp++;
            if (bus_n.DataOut[p*8 +: 8] !== exp_rd(1, p)) begin
               n_err++;
               $display("FAIL rand_nobypass cyc %0d port %0d: got %h want %h",
                        c, p, bus_n.DataOut[p*8 +: 8], exp_rd(1, p));
            end
            n_cmp++;
            if (bus_z.DataOut[p*8 +: 8] !== exp_rd(2, p)) begin
               n_err++;
               $display("FAIL rand_zero cyc %0d port %0d: got %h want %h",
                        c, p, bus_z.DataOut[p*8 +: 8], exp_rd(2, p));
            end
         end
         $display("rand %0d: we=%b wa=%0d d=%h clr=%b ra=%h dout=%h", c, we, waddr, din, clr,
                  raddr, bus_b.DataOut);
         tick();
      end
      clr = 1'b0; we = 1'b0;
   endtask

   task automatic test_wide_config();
      int n;
      we3 = 1'b0; clr3 = 1'b0; waddr3 = '0; din3 = '0; raddr3 = '0;
      rstn3 = 1'b1;
      n = 0;
      while (bus_w.Ready !== 1'b1 && n < 80) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 32) begin
         n_err++;
         $display("FAIL wide_ready_edges: Ready after %0d edges want 32", n);
      end
      we3 = 1'b1; waddr3 = 5'd17; din3 = 16'hBEEF;
      raddr3 = {5'd17, 5'd17, 5'd4, 5'd0};
      #2;
      n_cmp++;
      if (bus_w.DataOut !== {16'hBEEF, 16'hBEEF, 16'h0, 16'h0}) begin
         n_err++;
         $display("FAIL wide_bypass: got %h want beefbeef00000000", bus_w.DataOut);
      end
      tick();
      we3 = 1'b0;
      raddr3 = {5'd0, 5'd3, 5'd17, 5'd31};
      #2;
      n_cmp++;
      if (bus_w.DataOut !== {16'h0, 16'h0, 16'hBEEF, 16'h0}) begin
         n_err++;
         $display("FAIL wide_read: got %h want 00000000beef0000", bus_w.DataOut);
      end
      $display("test_wide_config: Ready after %0d edges, dout=%h", n, bus_w.DataOut);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_ready = 0; m_cnt = 0;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
      rstn = 1'b0; we = 1'b0; waddr = '0; din = '0; clr = 1'b0; raddr = '0;
      rstn3 = 1'b0; we3 = 1'b0; waddr3 = '0; din3 = '0; clr3 = 1'b0; raddr3 = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_clear_priority();
      test_reset_mid_sweep();
      test_random();
      test_wide_config();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, two-read combinational register file.
- Adds a configurable number of read ports and same-cycle write-to-read bypass.
- Optional hardwired zero register.
- Deterministic clearing: a sequential sweep that runs after reset or on request, with a Ready flag.
- Sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
W, 8, data path width in bits
D, 4, address pointer width; depth is 2**D entries
NR, 3, number of independent read ports (1..8)
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports combinationally
ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded

Ports:
Clk  input  1  clock; all state updates on rising edge
ResetN  input  1  synchronous, active-low reset
WriteEn  input  1  write request for this cycle
Waddr  input  D  write address
DataIn  input  W  write data
ClearReq  input  1  one-cycle pulse; starts a clear sweep of all entries
Raddr  input  NR*D  packed read addresses; port i uses bits [i*D +: D]
DataOut  output  NR*W  packed read data; port i drives bits [i*W +: W]
Ready  output  1  1 = file is initialised and accepting writes
ClearIdx  output  D  current sweep index (debug/verification visibility)

Behaviour:
- Reset: one clock; reset is synchronous and active-low, sampled on the rising edge of Clk.
  - While ResetN=0 at an edge: state<=CLEAR, ClearIdx<=0, Ready<=0.
  - DataOut reads 0 on all ports while Ready=0.
  - Entry contents are not guaranteed until the sweep completes.
- States: CLEAR, READY.
- CLEAR state:
  - Each edge with ResetN=1: Registers[ClearIdx]<=0, then ClearIdx<=ClearIdx+1.
  - On the edge that clears entry 2**D-1: state<=READY, Ready<=1, ClearIdx<=0 (counter wraps).
  - Ready therefore rises exactly 2**D edges after ResetN is first sampled high.
  - WriteEn is ignored; no entry other than Registers[ClearIdx] changes.
  - ClearReq is ignored; the sweep is not restarted.
  - ResetN=0 mid-sweep: ClearIdx returns to 0 and the sweep restarts from entry 0.
- READY state:
  - WriteEn=1 at an edge: Registers[Waddr]<=DataIn.
  - If ZERO_REG=1 and Waddr=0, the write is discarded.
  - ClearReq=1 at an edge: state<=CLEAR, Ready<=0, ClearIdx<=0.
  - Any simultaneous WriteEn in that same cycle is dropped; ClearReq has priority.
- Reads (combinational, all NR ports independent, any address, duplicates allowed):
  - Ready=0: DataOut[i]=0.
  - ZERO_REG=1 and Raddr[i]=0: DataOut[i]=0, regardless of bypass.
  - BYPASS=1 and WriteEn=1 and Ready=1 and ClearReq=0 and Raddr[i]=Waddr: DataOut[i]=DataIn.
  - Otherwise: DataOut[i]=Registers[Raddr[i]].
  - BYPASS=0: a read of a location written this cycle returns the old value; the new value is visible the next cycle.
- Latency:
  - Read: 0 cycles.
  - Write: visible on the next cycle, or the same cycle via bypass.
  - Clear: 2**D cycles.
- Widths: no arithmetic apart from ClearIdx, which increments modulo 2**D. Raddr and DataOut are packed with port 0 in the LSBs.
- Invalid parameter values (NR outside 1..8) are out of scope; elaboration behaviour is undefined.

Test Plan:
1. Default params. Hold ResetN=0 for 3 cycles, then release. Expected:
   - Ready=0 and every DataOut=0 through 15 edges.
   - Ready=1 after the 16th edge.
   - Every address then reads 0x00 on all 3 ports.
2. After Ready: write 0xA5 to addr 3 and 0x5A to addr 7 on consecutive cycles. Read Raddr={3,7,3}. Expected DataOut={0xA5,0x5A,0xA5}.
3. BYPASS=1: WriteEn=1, Waddr=9, DataIn=0x3C, with Raddr port1=9.
   - Same cycle: DataOut port1=0x3C.
   - Same stimulus with BYPASS=0: old value 0x00 this cycle, 0x3C next cycle.
4. ZERO_REG=1: write 0xFF to addr 0, then read addr 0 on all ports. Expected 0x00, including during the write cycle with BYPASS=1.
5. Fill all 16 entries with the value (addr+1), then pulse ClearReq together with WriteEn (addr 2, 0x77). Expected:
   - The 0x77 write is dropped.
   - Ready=0 for 16 cycles; WriteEn during the sweep has no effect.
   - Afterwards all entries read 0.
6. Start a clear sweep and assert ResetN=0 when ClearIdx=10; release after 1 cycle. Expected:
   - ClearIdx=0 after the reset edge.
   - Ready rises exactly 16 edges after release.
   - Parametrised rerun with W=16, D=5, NR=4: Ready rises after 32 edges.
